// File: rtl/gate_checker_if.sv
// gate_checker_if: stimulus/result bundle between gate_checker and its gate.
// master = checker side, slave = gate/observer side.
interface gate_checker_if;
  logic       start;
  logic       dut_y;
  logic       dut_a;
  logic       dut_b;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_count;
  logic [3:0] fail_vec;

  modport master (
    input  start,
    input  dut_y,
    output dut_a,
    output dut_b,
    output busy,
    output done,
    output pass,
    output err_count,
    output fail_vec
  );

  modport slave (
    output start,
    output dut_y,
    input  dut_a,
    input  dut_b,
    input  busy,
    input  done,
    input  pass,
    input  err_count,
    input  fail_vec
  );
endinterface

// File: rtl/gate_checker.sv
// gate_checker: walks a 2-input gate through {a,b}=00..11, compares y with TRUTH.
// Ports: clk, rst (sync, active-high); bus (master): start, dut_y in;
//   dut_a, dut_b, busy, done, pass, err_count, fail_vec out.
// Option: GATE_CHECKER_STOP_ON_FAIL_EN ends a run at the first mismatch.
module gate_checker #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter logic [3:0]  TRUTH         = 4'b1000
) (
  input logic           clk,
  input logic           rst,
  gate_checker_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] werr_q, werr_d;
  logic [3:0] wmap_q, wmap_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [2:0] err_q, err_d;
  logic [3:0] fvec_q, fvec_d;

  logic       mis;
  logic       last;

  assign mis = (bus.dut_y != TRUTH[idx_q]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      cnt_q   <= 8'd0;
      werr_q  <= 3'd0;
      wmap_q  <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 3'd0;
      fvec_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      werr_q  <= werr_d;
      wmap_q  <= wmap_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fvec_q  <= fvec_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    werr_d  = werr_q;
    wmap_d  = wmap_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
    fvec_d  = fvec_q;
    last    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          idx_d   = 2'd0;
          cnt_d   = 8'd0;
          werr_d  = 3'd0;
          wmap_d  = 4'd0;
          busy_d  = 1'b1;
          state_d = SETTLE;
        end
      end

      SETTLE: begin
        if (cnt_q == CNT_LAST) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      SAMPLE: begin
        if (mis) begin
          // saturate at 4: never wraps the 3-bit count
          werr_d        = (werr_q == 3'd4) ? 3'd4 : werr_q + 3'd1;
          wmap_d[idx_q] = 1'b1;
        end
`ifdef GATE_CHECKER_STOP_ON_FAIL_EN
        last = (idx_q == 2'd3) || mis;
`else
        last = (idx_q == 2'd3);
`endif
        if (last) begin
          busy_d  = 1'b0;
          state_d = DONE;
        end else begin
          // dut_a/dut_b follow idx, so the next vector appears this edge
          idx_d   = idx_q + 2'd1;
          cnt_d   = 8'd0;
          state_d = SETTLE;
        end
      end

      DONE: begin
        err_d   = werr_q;
        fvec_d  = wmap_q;
        pass_d  = (werr_q == 3'd0);
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.dut_a     = idx_q[1];
  assign bus.dut_b     = idx_q[0];
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.err_count = err_q;
  assign bus.fail_vec  = fvec_q;

endmodule

// File: tb/tb_gate_checker.sv
// tb_gate_checker: two checkers (SETTLE 1 and 3) driving modelled gates.
// Expected results come from XOR of gate and truth table plus latency math.
module tb_gate_checker;

  localparam int          S0 = 1;
  localparam int          S1 = 3;
  localparam logic [3:0]  T0 = 4'b1000;
  localparam logic [3:0]  T1 = 4'b1000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_r [2];
  logic [3:0] gate_r  [2];

  logic [1:0] vec_w  [2];
  logic       busy_w [2];
  logic       done_w [2];
  logic       pass_w [2];
  logic [2:0] err_w  [2];
  logic [3:0] fv_w   [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gate_checker_if if0 ();
  gate_checker_if if1 ();

  assign if0.start = start_r[0];
  assign if1.start = start_r[1];
  assign if0.dut_y = gate_r[0][{if0.dut_a, if0.dut_b}];
  assign if1.dut_y = gate_r[1][{if1.dut_a, if1.dut_b}];

  assign vec_w[0]  = {if0.dut_a, if0.dut_b};
  assign vec_w[1]  = {if1.dut_a, if1.dut_b};
  assign busy_w[0] = if0.busy;
  assign busy_w[1] = if1.busy;
  assign done_w[0] = if0.done;
  assign done_w[1] = if1.done;
  assign pass_w[0] = if0.pass;
  assign pass_w[1] = if1.pass;
  assign err_w[0]  = if0.err_count;
  assign err_w[1]  = if1.err_count;
  assign fv_w[0]   = if0.fail_vec;
  assign fv_w[1]   = if1.fail_vec;

  gate_checker #(.SETTLE_CYCLES(S0), .TRUTH(T0)) u0 (
    .clk (clk),
    .rst (rst),
    .bus (if0.master)
  );

  gate_checker #(.SETTLE_CYCLES(S1), .TRUTH(T1)) u1 (
    .clk (clk),
    .rst (rst),
    .bus (if1.master)
  );

  task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(int d, string tag);
    check({tag, "_vec"},  8'(vec_w[d]),  8'd0);
    check({tag, "_busy"}, 8'(busy_w[d]), 8'd0);
    check({tag, "_done"}, 8'(done_w[d]), 8'd0);
    check({tag, "_pass"}, 8'(pass_w[d]), 8'd0);
    check({tag, "_err"},  8'(err_w[d]),  8'd0);
    check({tag, "_fv"},   8'(fv_w[d]),   8'd0);
  endtask

  // Called #1 after an edge with checker d idle.
  task automatic run(int d, logic [3:0] g, bit repulse, string tag);
    int         s;
    int         last;
    int         eerr;
    int         lat;
    int         ndone;
    logic [3:0] mm;
    logic [3:0] emap;
    s    = (d == 0) ? S0 : S1;
    mm   = g ^ ((d == 0) ? T0 : T1);
    last = 3;
    emap = mm;
`ifdef GATE_CHECKER_STOP_ON_FAIL_EN
    emap = 4'd0;
    for (int i = 0; i < 4; i++) begin
      if (mm[i] && emap == 4'd0) begin
        last = i;
        emap = 4'(1 << i);
      end
    end
`endif
    eerr  = $countones(emap);
    lat   = (last + 1) * (s + 1) + 1;
    ndone = 0;

    gate_r[d]  = g;
    start_r[d] = 1'b1;
    tick();
    for (int t = 0; t <= lat + 2; t++) begin
      start_r[d] = (repulse && (t == 1 || t == 2)) ? 1'b1 : 1'b0;
      check($sformatf("%s_vec_t%0d", tag, t), 8'(vec_w[d]),
            8'((t / (s + 1) < last) ? t / (s + 1) : last));
      check($sformatf("%s_busy_t%0d", tag, t), 8'(busy_w[d]),
            8'(t <= lat - 2));
      check($sformatf("%s_done_t%0d", tag, t), 8'(done_w[d]),
            8'(t == lat));
      if (done_w[d] === 1'b1) ndone++;
      if (t >= lat) begin
        check($sformatf("%s_err_t%0d", tag, t), 8'(err_w[d]), 8'(eerr));
        check($sformatf("%s_fv_t%0d", tag, t), 8'(fv_w[d]), 8'(emap));
        check($sformatf("%s_pass_t%0d", tag, t), 8'(pass_w[d]),
              8'(eerr == 0));
      end
      tick();
    end
    start_r[d] = 1'b0;
    check({tag, "_ndone"}, 8'(ndone), 8'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int ndone;
    start_r[0] = 1'b0;
    start_r[1] = 1'b0;
    gate_r[0]  = 4'b1000;
    gate_r[1]  = 4'b1000;
    rst        = 1'b1;
    tick();
    tick();
    check_zero(0, "rst0");
    check_zero(1, "rst1");
    rst = 1'b0;
    tick();

    run(0, 4'b1000, 1'b0, "and");
    run(0, 4'b0000, 1'b0, "zero");
    run(0, 4'b1110, 1'b0, "or");
    run(0, 4'b1000, 1'b1, "repulse");

    gate_r[0]  = 4'b1000;
    start_r[0] = 1'b1;
    tick();
    start_r[0] = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    check_zero(0, "midrst");
    rst   = 1'b0;
    ndone = 0;
    for (int t = 0; t < 12; t++) begin
      if (done_w[0] === 1'b1) ndone++;
      check($sformatf("midrst_busy_t%0d", t), 8'(busy_w[0]), 8'd0);
      tick();
    end
    check("midrst_ndone", 8'(ndone), 8'd0);

    run(0, 4'b1000, 1'b0, "postrst");
    run(1, 4'b1000, 1'b0, "s3_and");
    run(1, 4'b1110, 1'b0, "s3_or");

    for (int i = 0; i < 10; i++) begin
      run(int'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
          1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
